// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card -> account -> PIN -> menu, with idle timeout and try limit.
// Optional sticky account lockout after MAX_TRIES wrong PINs: define ATM_LOCKOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | no card; waiting for card_in
// WAIT_ACC  | card present; waiting for acc_valid
// CHECK_ACC | authenticator lookup of auth_acc_num
// WAIT_PIN  | account accepted; waiting for pin_valid
// CHECK_PIN | authenticator PIN compare
// MENU      | authenticated session; waiting for logout
// EJECT     | one-cycle card_eject pulse
module atm_session_ctrl #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_TRIES      = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        card_in,
   input  logic        acc_valid,
   input  logic [3:0]  acc_num,
   input  logic        pin_valid,
   input  logic [15:0] pin,
   input  logic        logout,
   output logic [3:0]  auth_acc_num,
   output logic [15:0] auth_pin,
   input  logic        auth_found,
   input  logic [3:0]  auth_index,
   input  logic        auth_pin_ok,
   output logic        session_active,
   output logic [3:0]  session_index,
   output logic        card_eject,
   output logic [2:0]  err_code,
   output logic [2:0]  state_out
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_ACC  = 3'd1,
      S_CHECK_ACC = 3'd2,
      S_WAIT_PIN  = 3'd3,
      S_CHECK_PIN = 3'd4,
      S_MENU      = 3'd5,
      S_EJECT     = 3'd6
   } state_t;

   localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TRW = $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0]  TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TRW-1:0] TRIES_MAX = TRW'(MAX_TRIES);
   localparam logic [TRW-1:0] TRIES_LST = TRW'(MAX_TRIES - 1);

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_NO_ACC  = 3'd1;
   localparam logic [2:0] ERR_BAD_PIN = 3'd2;
   localparam logic [2:0] ERR_LOCKED  = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;

   state_t           state;
   logic [TW-1:0]    tmo_cnt;
   logic [TRW-1:0]   tries;
   logic             tmo_hit;
   logic             acc_locked;

   assign tmo_hit   = (tmo_cnt == '0);
   assign state_out = state;

`ifdef ATM_LOCKOUT_EN
   logic [9:0]  lock_map;
   logic [15:0] lock_ext;
   logic [15:0] lock_set;

   assign lock_ext   = {6'd0, lock_map};
   assign acc_locked = lock_ext[auth_index];
   assign lock_set   = 16'd1 << session_index;

   always_ff @(posedge clk) begin
      if (!rst_n)
         lock_map <= '0;
      else if (state == S_CHECK_PIN && card_in && !auth_pin_ok && tries >= TRIES_LST)
         lock_map <= lock_map | lock_set[9:0];
   end
`else
   assign acc_locked = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         tmo_cnt        <= '0;
         tries          <= '0;
         auth_acc_num   <= '0;
         auth_pin       <= '0;
         session_active <= 1'b0;
         session_index  <= '0;
         card_eject     <= 1'b0;
         err_code       <= ERR_NONE;
      end else begin
         card_eject <= 1'b0;
         // down-counter reloads everywhere except while dwelling in a waiting state
         tmo_cnt    <= TMO_LOAD;
         if (state != S_IDLE && !card_in) begin
            state          <= S_IDLE;
            session_active <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (card_in) begin
                     state    <= S_WAIT_ACC;
                     err_code <= ERR_NONE;
                     tries    <= '0;
                  end
               end
               S_WAIT_ACC: begin
                  if (tmo_hit) begin
                     state      <= S_EJECT;
                     card_eject <= 1'b1;
                     err_code   <= ERR_TIMEOUT;
                  end else if (acc_valid) begin
                     auth_acc_num <= acc_num;
                     state        <= S_CHECK_ACC;
                  end else begin
                     tmo_cnt <= tmo_cnt - TW'(1);
                  end
               end
               S_CHECK_ACC: begin
                  if (!auth_found) begin
                     state      <= S_EJECT;
                     card_eject <= 1'b1;
                     err_code   <= ERR_NO_ACC;
                  end else if (acc_locked) begin
                     state      <= S_EJECT;
                     card_eject <= 1'b1;
                     err_code   <= ERR_LOCKED;
                  end else begin
                     session_index <= auth_index;
                     state         <= S_WAIT_PIN;
                  end
               end
               S_WAIT_PIN: begin
                  if (tmo_hit) begin
                     state      <= S_EJECT;
                     card_eject <= 1'b1;
                     err_code   <= ERR_TIMEOUT;
                  end else if (pin_valid) begin
                     auth_pin <= pin;
                     state    <= S_CHECK_PIN;
                  end else begin
                     tmo_cnt <= tmo_cnt - TW'(1);
                  end
               end
               S_CHECK_PIN: begin
                  if (auth_pin_ok) begin
                     state          <= S_MENU;
                     session_active <= 1'b1;
                     tries          <= '0;
                     err_code       <= ERR_NONE;
                  end else begin
                     err_code <= ERR_BAD_PIN;
                     tries    <= (tries == TRIES_MAX) ? tries : tries + TRW'(1);
                     if (tries >= TRIES_LST) begin
                        state      <= S_EJECT;
                        card_eject <= 1'b1;
                     end else begin
                        state <= S_WAIT_PIN;
                     end
                  end
               end
               S_MENU: begin
                  if (tmo_hit) begin
                     state          <= S_EJECT;
                     card_eject     <= 1'b1;
                     session_active <= 1'b0;
                     err_code       <= ERR_TIMEOUT;
                  end else if (logout) begin
                     state          <= S_EJECT;
                     card_eject     <= 1'b1;
                     session_active <= 1'b0;
                     err_code       <= ERR_NONE;
                  end else begin
                     tmo_cnt <= tmo_cnt - TW'(1);
                  end
               end
               S_EJECT: begin
                  state          <= S_IDLE;
                  session_active <= 1'b0;
               end
               default: begin
                  state          <= S_IDLE;
                  session_active <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl with a small behavioural authenticator.
// Expectations adapt to ATM_LOCKOUT_EN when the build defines it.
module tb_atm_session_ctrl;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        card_in;
   logic        acc_valid;
   logic [3:0]  acc_num;
   logic        pin_valid;
   logic [15:0] pin;
   logic        logout;
   logic [3:0]  auth_acc_num;
   logic [15:0] auth_pin;
   logic        auth_found;
   logic [3:0]  auth_index;
   logic        auth_pin_ok;
   logic        session_active;
   logic [3:0]  session_index;
   logic        card_eject;
   logic [2:0]  err_code;
   logic [2:0]  state_out;

   int n_pass  = 0;
   int n_total = 0;

   atm_session_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_TRIES(3)) dut (
      .clk(clk), .rst_n(rst_n), .card_in(card_in),
      .acc_valid(acc_valid), .acc_num(acc_num),
      .pin_valid(pin_valid), .pin(pin), .logout(logout),
      .auth_acc_num(auth_acc_num), .auth_pin(auth_pin),
      .auth_found(auth_found), .auth_index(auth_index), .auth_pin_ok(auth_pin_ok),
      .session_active(session_active), .session_index(session_index),
      .card_eject(card_eject), .err_code(err_code), .state_out(state_out)
   );

   always #5 clk = ~clk;

   // accounts 0..9 exist; account 3 PIN 4567, every other account PIN 2222
   assign auth_found  = (auth_acc_num < 4'd10);
   assign auth_index  = auth_acc_num;
   assign auth_pin_ok = auth_found &&
                        (auth_pin == ((auth_acc_num == 4'd3) ? 16'd4567 : 16'd2222));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic enter_acc(input logic [3:0] a);
      card_in = 1'b1;
      step();
      acc_valid = 1'b1;
      acc_num   = a;
      step();
      acc_valid = 1'b0;
      step();
   endtask

   task automatic give_pin(input logic [15:0] p);
      pin_valid = 1'b1;
      pin       = p;
      step();
      pin_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; card_in = 1'b0; acc_valid = 1'b0; acc_num = '0;
      pin_valid = 1'b0; pin = '0; logout = 1'b0;
      step(); step();
      rst_n = 1'b1;
      chk("rst_state",  32'(state_out), 0);
      chk("rst_eject",  32'(card_eject), 0);
      chk("rst_active", 32'(session_active), 0);
      chk("rst_err",    32'(err_code), 0);
      chk("rst_accnum", 32'(auth_acc_num), 0);
      chk("rst_pin",    32'(auth_pin), 0);

      // good session on account 3
      card_in = 1'b1;
      step();
      chk("idle_to_wait_acc", 32'(state_out), 1);
      acc_valid = 1'b1; acc_num = 4'd3;
      step();
      acc_valid = 1'b0;
      chk("check_acc_state", 32'(state_out), 2);
      chk("auth_acc_num_3",  32'(auth_acc_num), 3);
      step();
      chk("wait_pin_state", 32'(state_out), 3);
      acc_valid = 1'b1; acc_num = 4'd7;
      step();
      acc_valid = 1'b0;
      chk("acc_ignored_state",  32'(state_out), 3);
      chk("acc_ignored_accnum", 32'(auth_acc_num), 3);
      give_pin(16'd4567);
      chk("check_pin_state", 32'(state_out), 4);
      chk("auth_pin_4567",   32'(auth_pin), 4567);
      step();
      chk("menu_state",    32'(state_out), 5);
      chk("menu_active",   32'(session_active), 1);
      chk("menu_index",    32'(session_index), 3);
      chk("menu_err",      32'(err_code), 0);
      logout = 1'b1;
      step();
      logout = 1'b0; card_in = 1'b0;
      chk("logout_eject_state", 32'(state_out), 6);
      chk("logout_eject_pulse", 32'(card_eject), 1);
      chk("logout_inactive",    32'(session_active), 0);
      step();
      chk("logout_idle",     32'(state_out), 0);
      chk("logout_pulse_end", 32'(card_eject), 0);

      // unknown account 12
      enter_acc(4'd12);
      chk("noacc_eject_state", 32'(state_out), 6);
      chk("noacc_err",         32'(err_code), 1);
      chk("noacc_pulse",       32'(card_eject), 1);
      card_in = 1'b0;
      step();
      chk("noacc_idle",     32'(state_out), 0);
      chk("noacc_err_held", 32'(err_code), 1);

      // three wrong PINs on account 5
      enter_acc(4'd5);
      chk("acc5_wait_pin", 32'(state_out), 3);
      chk("acc5_err_clr",  32'(err_code), 0);
      for (int i = 1; i <= 3; i++) begin
         give_pin(16'd1111);
         step();
         chk("wrong_pin_err", 32'(err_code), 2);
         chk("wrong_pin_state", 32'(state_out), (i < 3) ? 32'd3 : 32'd6);
         chk("wrong_pin_pulse", 32'(card_eject), (i < 3) ? 32'd0 : 32'd1);
      end
      card_in = 1'b0;
      step();
      enter_acc(4'd5);
`ifdef ATM_LOCKOUT_EN
      chk("locked_state", 32'(state_out), 6);
      chk("locked_err",   32'(err_code), 3);
`else
      chk("relogin_state", 32'(state_out), 3);
      chk("relogin_err",   32'(err_code), 0);
`endif
      card_in = 1'b0;
      step();

      // idle timeout in WAIT_PIN
      enter_acc(4'd3);
      repeat (TMO - 1) step();
      chk("tmo_not_yet", 32'(state_out), 3);
      step();
      chk("tmo_eject_state", 32'(state_out), 6);
      chk("tmo_err",         32'(err_code), 4);
      chk("tmo_pulse",       32'(card_eject), 1);
      card_in = 1'b0;
      step();

      // a PIN entry just before the deadline restarts the count
      enter_acc(4'd3);
      repeat (TMO - 2) step();
      give_pin(16'd1111);
      step();
      chk("restart_back_wait", 32'(state_out), 3);
      repeat (TMO - 1) step();
      chk("restart_not_yet", 32'(state_out), 3);
      step();
      chk("restart_tmo_state", 32'(state_out), 6);
      chk("restart_tmo_err",   32'(err_code), 4);
      card_in = 1'b0;
      step();

      // card pulled in the same cycle as logout
      enter_acc(4'd3);
      give_pin(16'd4567);
      step();
      chk("pull_menu", 32'(state_out), 5);
      logout = 1'b1; card_in = 1'b0;
      step();
      logout = 1'b0;
      chk("pull_idle",     32'(state_out), 0);
      chk("pull_no_eject", 32'(card_eject), 0);
      chk("pull_inactive", 32'(session_active), 0);
      chk("pull_err_kept", 32'(err_code), 0);

      // reset during CHECK_PIN
      enter_acc(4'd3);
      give_pin(16'd1111);
      chk("pre_rst_check_pin", 32'(state_out), 4);
      rst_n = 1'b0;
      step();
      chk("midrst_state",  32'(state_out), 0);
      chk("midrst_eject",  32'(card_eject), 0);
      chk("midrst_accnum", 32'(auth_acc_num), 0);
      chk("midrst_pin",    32'(auth_pin), 0);
      chk("midrst_index",  32'(session_index), 0);
      chk("midrst_err",    32'(err_code), 0);
      rst_n = 1'b1;
      card_in = 1'b0;
      step();
      enter_acc(4'd5);
      chk("post_rst_acc5_usable", 32'(state_out), 3);
      card_in = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
